// File: rtl/irq_source_pkg.sv
// Shared definitions for the irq_source block.
// Holds the FSM state encoding, the MODE encodings, the register byte offsets
// inside the window, the default window/acknowledge addresses and a byte-merge
// helper used by the register file.
package irq_source_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCnt   = 3'd2,
    StWatch = 3'd3,
    StPend  = 3'd4
  } state_e;

  // MODE value 3 is not a distinct mode; the FSM treats it like one-shot.
  typedef enum logic [1:0] {
    ModeOneShot    = 2'd0,
    ModePeriodic   = 2'd1,
    ModePcMatch    = 2'd2,
    ModeOneShotAlt = 2'd3
  } mode_e;

  // Byte offsets of the registers from the window base.
  localparam logic [3:0] OffCtrl   = 4'h0;
  localparam logic [3:0] OffPreset = 4'h4;
  localparam logic [3:0] OffCount  = 4'h8;
  localparam logic [3:0] OffTarget = 4'hc;

  localparam logic [31:0] DefaultBaseAddr = 32'h0000_7f00;
  localparam logic [31:0] DefaultAckAddr  = 32'h0000_7f20;

  // Replace only the byte lanes of old_val that are enabled in be.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_source_regs.sv
// Register file and bus decode for irq_source.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   addr, byteen, wdata   CPU data-bus write/read request (addr[1:0] ignored)
//   count                 live COUNT value owned by the FSM, for read-back
//   en_clr                FSM request to clear CTRL.EN (one-shot/PC-match ack)
//   rdata                 combinational read data, 0 outside the window
//   ctrl_en/mode/im       CTRL fields
//   preset, target        PRESET and TARGET registers
//   ctrl_wr               write to CTRL touching byte 0 (the only live byte)
//   ack_wr                any write to the acknowledge word
module irq_source_regs
  import irq_source_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter logic [31:0] ACK_ADDR  = DefaultAckAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  input  logic [31:0] count,
  input  logic        en_clr,
  output logic [31:0] rdata,
  output logic        ctrl_en,
  output mode_e       ctrl_mode,
  output logic        ctrl_im,
  output logic [31:0] preset,
  output logic [31:0] target,
  output logic        ctrl_wr,
  output logic        ack_wr
);

  logic        wr;
  logic [29:0] word_off;
  logic        in_win;
  logic [1:0]  sel;
  logic        preset_wr;
  logic        target_wr;
  logic        unused_addr_lsb;

  logic        en_q;
  mode_e       mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] target_q;

  assign wr       = |byteen;
  assign word_off = addr[31:2] - BASE_ADDR[31:2];
  assign in_win   = (word_off < 30'd4);
  assign sel      = word_off[1:0];

  // CTRL has no state above bit 3, so a write without byte 0 changes nothing.
  assign ctrl_wr   = wr & in_win & (sel == OffCtrl[3:2]) & byteen[0];
  assign preset_wr = wr & in_win & (sel == OffPreset[3:2]);
  assign target_wr = wr & in_win & (sel == OffTarget[3:2]);
  assign ack_wr    = wr & (addr[31:2] == ACK_ADDR[31:2]);

  assign unused_addr_lsb = ^addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      preset_q <= '0;
      target_q <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q   <= wdata[0];
        mode_q <= mode_e'(wdata[2:1]);
        im_q   <= wdata[3];
      end
      // Only raised on an acknowledge, which cannot be a CTRL write unless the
      // ack word aliases CTRL; the FSM then ends in IDLE so EN must follow.
      if (en_clr) en_q <= 1'b0;
      if (preset_wr) preset_q <= merge_bytes(preset_q, wdata, byteen);
      if (target_wr) target_q <= merge_bytes(target_q, wdata, byteen);
    end
  end

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (sel)
        OffCtrl[3:2]:   rdata = {28'd0, im_q, mode_q, en_q};
        OffPreset[3:2]: rdata = preset_q;
        OffCount[3:2]:  rdata = count;
        default:        rdata = target_q;
      endcase
    end
  end

  assign ctrl_en   = en_q;
  assign ctrl_mode = mode_q;
  assign ctrl_im   = im_q;
  assign preset    = preset_q;
  assign target    = target_q;

endmodule

// File: rtl/irq_source.sv
// Programmable interrupt source: one-shot / periodic down-counter or
// committed-PC match, with a memory-mapped register window and an
// acknowledge word.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   addr, byteen, wdata   CPU data-bus access (write when byteen != 0)
//   rdata                 combinational read data for addr
//   macroscopic_pc        CPU committed PC for PC-match mode
//   interrupt             level request, pending AND CTRL.IM (registered)
module irq_source
  import irq_source_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter logic [31:0] ACK_ADDR  = DefaultAckAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] macroscopic_pc,
  output logic        interrupt
);

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        en_clr;

  logic        ctrl_en;
  mode_e       ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] target;
  logic        ctrl_wr;
  logic        ack_wr;
  logic        pc_hit;
  logic        unused_lsb;

  irq_source_regs #(
    .BASE_ADDR (BASE_ADDR),
    .ACK_ADDR  (ACK_ADDR)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .byteen    (byteen),
    .wdata     (wdata),
    .count     (count_q),
    .en_clr    (en_clr),
    .rdata     (rdata),
    .ctrl_en   (ctrl_en),
    .ctrl_mode (ctrl_mode),
    .ctrl_im   (ctrl_im),
    .preset    (preset),
    .target    (target),
    .ctrl_wr   (ctrl_wr),
    .ack_wr    (ack_wr)
  );

  assign pc_hit     = (macroscopic_pc[31:2] == target[31:2]);
  assign unused_lsb = ^{macroscopic_pc[1:0], target[1:0], ctrl_en};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    en_clr    = 1'b0;

    if (ctrl_wr && !wdata[0]) begin
      // Disable beats everything, including a same-cycle acknowledge.
      state_d   = StIdle;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_wr) begin
            state_d = (wdata[2:1] == ModePcMatch) ? StWatch : StLoad;
          end
        end
        StLoad: begin
          count_d = preset;
          state_d = StCnt;
        end
        StCnt: begin
          if (count_q == 32'd0) begin
            pending_d = 1'b1;
            state_d   = StPend;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
        StWatch: begin
          if (pc_hit) begin
            pending_d = 1'b1;
            state_d   = StPend;
          end
        end
        StPend: begin
          if (ack_wr) begin
            pending_d = 1'b0;
            if (ctrl_mode == ModePeriodic) begin
              state_d = StLoad;
            end else begin
              state_d = StIdle;
              en_clr  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Both terms are flops, so no input reaches interrupt combinationally.
  assign interrupt = pending_q & ctrl_im;

endmodule

// File: doc/irq_source.md
IRQ_SOURCE -- requirements
Module: irq_source

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_7f00, word-aligned base of the register window.
REQ-002 Parameter ACK_ADDR, default 32'h0000_7f20, word address the CPU writes to acknowledge the interrupt.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port addr  input  32  CPU data-bus byte address; bits [1:0] are ignored.
REQ-006 Port byteen  input  4  per-byte write enables; a write occurs only when byteen != 0.
REQ-007 Port wdata  input  32  write data, byte lanes qualified by byteen.
REQ-008 Port rdata  output  32  combinational read data for addr.
REQ-009 Port macroscopic_pc  input  32  CPU committed PC; bits [1:0] are ignored.
REQ-010 Port interrupt  output  1  level interrupt request to the CPU.

Function
REQ-011 The register map SHALL be: BASE+0 CTRL, with EN in bit 0, MODE in bits [2:1] and IM in bit 3; BASE+4 PRESET; BASE+8 COUNT (read-only); BASE+12 TARGET.
REQ-012 MODE values SHALL be: 0 one-shot timer; 1 periodic timer; 2 PC match; 3 behaves as 0.
REQ-013 Writes SHALL merge only the enabled bytes into the addressed register.
REQ-014 Writes to COUNT, to unmapped offsets, and to reserved CTRL bits [31:4] SHALL be ignored.
REQ-015 rdata SHALL return the addressed register (CTRL bits [31:4] read 0); rdata is 0 for any address outside the window.
REQ-016 The FSM states SHALL be IDLE, LOAD, CNT, WATCH and PEND.
REQ-017 IDLE: a CTRL write setting EN=1 moves to LOAD when MODE!=2, and to WATCH when MODE=2.
REQ-018 LOAD: COUNT<=PRESET; next state CNT.
REQ-019 CNT: if COUNT==0, set pending and go to PEND; otherwise COUNT<=COUNT-1.
REQ-020 WATCH: if (macroscopic_pc & ~3)==(TARGET & ~3), set pending and go to PEND.
REQ-021 interrupt SHALL equal pending AND IM, driven from registers only (no combinational path from inputs).
REQ-022 PEND: a write with byteen!=0 to ACK_ADDR (word-compared) SHALL clear pending.
REQ-023 On that acknowledge, the next state SHALL be LOAD in periodic mode; in one-shot and PC-match modes it is IDLE and EN is cleared.
REQ-024 Timing: a CTRL write with EN=1 and PRESET=N at edge t SHALL assert interrupt after edge t+N+2 (PRESET=0 gives t+2).
REQ-025 A CTRL write with EN=0 in any state SHALL force IDLE and clear pending in that same edge; COUNT holds its value.
REQ-026 A CTRL write with EN=1 while not in IDLE SHALL update MODE and IM only; no restart occurs.
REQ-027 An acknowledge outside PEND SHALL have no effect.
REQ-028 PRESET and TARGET writes during CNT or WATCH SHALL take effect only at the next LOAD or next compare.
REQ-029 COUNT SHALL never wrap below 0.
REQ-030 When a CTRL write with EN=0 and an acknowledge occur in the same cycle, the CTRL write SHALL win.

Reset
REQ-031 While reset is low, the FSM SHALL be in IDLE, and CTRL, PRESET, COUNT, TARGET and pending SHALL be 0; interrupt and rdata for in-window addresses SHALL be 0.
REQ-032 Reset asserted mid-count or mid-PEND SHALL drop interrupt immediately (asynchronously); operation resumes only after a new CTRL write.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the MODE encodings, the register offsets and the default BASE_ADDR/ACK_ADDR constants.
REQ-034 A single sub-module, irq_source_regs, SHALL implement byte-merge writes and read decode; the FSM and counter live in irq_source.

Verification
REQ-035 One-shot: PRESET=3, then write CTRL=0x9 at edge t -> interrupt rises after edge t+5; ACK write to 0x7f20 -> interrupt low the next edge, state IDLE, CTRL reads 0x8.
REQ-036 Periodic: PRESET=2, CTRL=0xB, acknowledge each request -> interrupt reasserts 4 cycles after every acknowledge; COUNT reads 2,1,0 per period.
REQ-037 PC match: TARGET=0x3010, CTRL=0xD, then drive macroscopic_pc 0x3008, 0x300c, 0x3012 -> interrupt rises on the edge after 0x3012 is driven; after the acknowledge, a repeat of 0x3010 raises nothing.
REQ-038 Byte writes: write PRESET with byteen=4'b0010 and wdata=0xAABBCCDD over 0x11223344 -> PRESET reads 0x1122CC44; a write to COUNT is ignored.
REQ-039 Masking/abort: IM=0 leaves interrupt low while pending is set; setting IM=1 raises interrupt the next edge; a CTRL=0 write in the same cycle as an acknowledge -> IDLE with pending 0.
REQ-040 Reset: assert reset low mid-CNT with interrupt high -> interrupt 0 with no clock edge, and all registers read 0.
